// File: rtl/gfx_bus_pkg.sv
// Shared bus map for the graphics bus: word layout, device addresses and
// the command-field layout of graphics payloads.
package gfx_bus_pkg;

  localparam int BUS_W    = 32;
  localparam int ADDR_W   = 2;
  localparam int ADDR_LSB = 30;
  localparam int DATA_W   = 24;

  typedef enum logic [ADDR_W-1:0] {
    DEV_SYS = 2'd0,
    DEV_SND = 2'd1,
    DEV_GFX = 2'd2,
    DEV_IO  = 2'd3
  } dev_addr_e;

  // Graphics payload: opcode in bits [23:16], operand in [15:0].
  localparam int OPC_LSB = 16;
  localparam int OPC_W   = 8;

  typedef enum logic [OPC_W-1:0] {
    OPC_NOP   = 8'h00,
    OPC_CLEAR = 8'h01,
    OPC_FILL  = 8'h02,
    OPC_BLIT  = 8'h03
  } gfx_opc_e;

  function automatic logic [OPC_W-1:0] cmd_opcode(input logic [DATA_W-1:0] payload);
    return payload[OPC_LSB +: OPC_W];
  endfunction

endpackage

// File: rtl/sync_fifo_sa.sv
// Show-ahead synchronous FIFO with registered head data/valid, fill level and
// full flag. A push into an empty FIFO is presented at the same edge it is stored.
module sync_fifo_sa #(
  parameter int DATA_W = 24,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [DATA_W-1:0]          wr_data,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              full_q, full_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              push_ok, pop, has_next;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    push_ok    = push && !full_q;
    pop        = rd_valid_q && rd_ready;
    wr_ptr_d   = wr_ptr_q + PTR_W'(push_ok);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    level_d    = level_q;
    if (push_ok && !pop)      level_d = level_q + 1'b1;
    else if (pop && !push_ok) level_d = level_q - 1'b1;
    full_d     = (level_d == LVL_W'(DEPTH));
    rd_valid_d = (level_d != '0);

    // Next head comes from storage if an older entry remains, else bypasses the incoming word.
    has_next   = pop ? (level_q > LVL_W'(1)) : (level_q != '0);
    rd_data_d  = rd_data_q;
    if (has_next)     rd_data_d = mem_q[rd_ptr_d];
    else if (push_ok) rd_data_d = wr_data;
  end

  // NOTE: storage needs no reset; pointers and level define which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      full_q     <= full_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign level    = level_q;
  assign full     = full_q;

endmodule

// File: rtl/bus_cmd_fifo_connector.sv
// Bus-to-stream connector: accepts bus words addressed to this device, buffers
// their payloads in a show-ahead FIFO and tracks dropped words for the CPU.
module bus_cmd_fifo_connector
  import gfx_bus_pkg::*;
#(
  parameter int BUS_W    = gfx_bus_pkg::BUS_W,
  parameter int ADDR_W   = gfx_bus_pkg::ADDR_W,
  parameter int ADDR_LSB = gfx_bus_pkg::ADDR_LSB,
  parameter int DEV_ADDR = int'(DEV_GFX),
  parameter int DATA_W   = gfx_bus_pkg::DATA_W,  // must not exceed ADDR_LSB
  parameter int DEPTH    = 8,
  parameter int CNT_W    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [BUS_W-1:0]         in,
  input  logic                     in_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     overflow,
  input  logic                     ovf_clr,
  output logic [CNT_W-1:0]         drop_cnt
);

  logic             match, drop;
  logic             overflow_q, overflow_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic             unused_in;

  // Bits between the payload and the address field carry nothing for this device.
  assign unused_in = ^in;

  sync_fifo_sa #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (match),
    .wr_data  (in[DATA_W-1:0]),
    .rd_data  (out_data),
    .rd_valid (out_valid),
    .rd_ready (out_ready),
    .level    (level),
    .full     (full)
  );

  always_comb begin
    match      = in_valid && (in[ADDR_LSB +: ADDR_W] == ADDR_W'(DEV_ADDR));
    drop       = match && full;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    // A drop in the same cycle as a clear wins and restarts the count at one.
    if (drop) begin
      overflow_d = 1'b1;
      if (ovf_clr)           drop_cnt_d = CNT_W'(1);
      else if (!(&drop_cnt_q)) drop_cnt_d = drop_cnt_q + 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_bus_cmd_fifo_connector.sv
// Self-checking bench: table of directed vectors plus scripted sequences, with
// a behavioural model and a payload scoreboard checking every cycle.
module tb_bus_cmd_fifo_connector;

  localparam int DEPTH  = 8;
  localparam int DATA_W = 24;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [31:0]       in = '0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [3:0]        level;
  logic              full;
  logic              overflow;
  logic              ovf_clr = 1'b0;
  logic [CNT_W-1:0]  drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state
  int                m_level = 0;
  bit                m_ovf   = 0;
  int                m_cnt   = 0;
  logic [DATA_W-1:0] sb[$];

  bus_cmd_fifo_connector #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in        (in),
    .in_valid  (in_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .full      (full),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive, run the model, advance, compare.
  task automatic cycle(input bit r, input logic [31:0] w, input bit iv,
                       input bit rdy, input bit clr);
    bit match, push, drop, pop;
    rst = r; in = w; in_valid = iv; out_ready = rdy; ovf_clr = clr;
    if (!r && m_level != 0) check("head_data", 32'(out_data), 32'(sb[0]));
    match = iv && (w[31:30] == 2'd2);
    push  = !r && match && (m_level != DEPTH);
    drop  = !r && match && (m_level == DEPTH);
    pop   = !r && (m_level != 0) && rdy;
    if (pop)  void'(sb.pop_front());
    if (push) sb.push_back(w[DATA_W-1:0]);
    if (r) begin
      m_level = 0; m_ovf = 0; m_cnt = 0; sb.delete();
    end else begin
      m_level = m_level + int'(push) - int'(pop);
      if (drop) begin
        m_ovf = 1;
        m_cnt = clr ? 1 : ((m_cnt == 255) ? 255 : m_cnt + 1);
      end else if (clr) begin
        m_ovf = 0; m_cnt = 0;
      end
    end
    @(posedge clk); #1;
    check("level",     32'(level),     32'(m_level));
    check("full",      32'(full),      32'(m_level == DEPTH));
    check("out_valid", 32'(out_valid), 32'(m_level != 0));
    check("overflow",  32'(overflow),  32'(m_ovf));
    check("drop_cnt",  32'(drop_cnt),  32'(m_cnt));
    if (r) check("reset_data", 32'(out_data), 32'h0);
  endtask

  typedef struct {
    bit          r;
    logic [31:0] w;
    bit          iv;
    bit          rdy;
    bit          chk_data;
    int          exp_level;
    bit          exp_valid;
    logic [23:0] exp_data;
  } vec_t;

  initial begin
    vec_t vecs[7];
    vecs[0] = '{1'b1, 32'h0,         1'b0, 1'b0, 1'b1, 0, 1'b0, 24'h0};
    vecs[1] = '{1'b0, 32'h8001_0000, 1'b1, 1'b0, 1'b1, 1, 1'b1, 24'h01_0000};
    vecs[2] = '{1'b0, 32'h4002_0000, 1'b1, 1'b0, 1'b1, 1, 1'b1, 24'h01_0000};
    vecs[3] = '{1'b0, 32'h8002_0000, 1'b0, 1'b0, 1'b1, 1, 1'b1, 24'h01_0000};
    vecs[4] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 0, 1'b0, 24'h01_0000};
    vecs[5] = '{1'b0, 32'h4002_0000, 1'b1, 1'b0, 1'b0, 0, 1'b0, 24'h0};
    vecs[6] = '{1'b0, 32'h8002_0000, 1'b0, 1'b0, 1'b0, 0, 1'b0, 24'h0};

    // Single word, address filter and data retention.
    for (int i = 0; i < 7; i++) begin
      cycle(vecs[i].r, vecs[i].w, vecs[i].iv, vecs[i].rdy, 1'b0);
      check($sformatf("vec%0d_level", i), 32'(level), 32'(vecs[i].exp_level));
      check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
      if (vecs[i].chk_data)
        check($sformatf("vec%0d_data", i), 32'(out_data), 32'(vecs[i].exp_data));
    end

    // Burst of 10 into depth 8 while stalled, then drain.
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 32'h8000_0000 | 32'(i), 1'b1, 1'b0, 1'b0);
      if (i == 7) check("burst_full_at_8", 32'(full), 32'h1);
    end
    check("burst_overflow", 32'(overflow), 32'h1);
    check("burst_drop_cnt", 32'(drop_cnt), 32'h2);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain_word%0d", i), {8'h0, out_data}, 32'(i));
      cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    end
    check("drain_level", 32'(level), 32'h0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

    // Continuous streaming with the consumer always ready.
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 32'h8000_0100 + 32'(i), 1'b1, 1'b1, 1'b0);
      check("stream_level_le1", 32'(level <= 4'd1), 32'h1);
    end
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    check("stream_overflow", 32'(overflow), 32'h0);

    // Clear versus drop in the same cycle.
    for (int i = 0; i < 9; i++) cycle(1'b0, 32'h8000_0200 + 32'(i), 1'b1, 1'b0, 1'b0);
    check("pre_clr_cnt", 32'(drop_cnt), 32'h1);
    cycle(1'b0, 32'h8000_0300, 1'b1, 1'b0, 1'b1);
    check("clr_drop_ovf", 32'(overflow), 32'h1);
    check("clr_drop_cnt", 32'(drop_cnt), 32'h1);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    check("clr_only_ovf", 32'(overflow), 32'h0);
    check("clr_only_cnt", 32'(drop_cnt), 32'h0);

    // Reset with 5 entries stored, a push and a ready consumer all in the reset cycle.
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    check("pre_rst_level", 32'(level), 32'h5);
    cycle(1'b1, 32'h8000_0400, 1'b1, 1'b1, 1'b0);
    check("rst_level", 32'(level), 32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);
    cycle(1'b0, 32'h8000_0500, 1'b1, 1'b0, 1'b0);
    check("post_rst_data", 32'(out_data), 32'h500);
    check("post_rst_level", 32'(level), 32'h1);
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
